// File: rtl/ahb_lite_master.sv
// AHB-Lite bus master: turns single/INCR word commands into pipelined address and data
// phases, returning read data and completion/error status on a response port.
module ahb_lite_master #(
    parameter int AddrBusWidth = 32,
    parameter int DataBusWidth = 32,
    parameter int MaxBurstLen  = 16,
    localparam int LW          = $clog2(MaxBurstLen) + 1
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [AddrBusWidth-1:0] cmd_addr,
    input  logic [LW-1:0]           cmd_len,
    input  logic [DataBusWidth-1:0] wr_data,
    output logic                    wr_pop,
    output logic                    rsp_valid,
    output logic [DataBusWidth-1:0] rsp_rdata,
    output logic                    rsp_last,
    output logic                    rsp_error,
    output logic [AddrBusWidth-1:0] HADDR,
    output logic [1:0]              HTRANS,
    output logic                    HWRITE,
    output logic [DataBusWidth-1:0] HWDATA,
    input  logic [DataBusWidth-1:0] HRDATA,
    input  logic                    HREADY,
    input  logic                    HRESP
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_BURST = 3'd2;
    localparam logic [2:0] S_LAST  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    logic [2:0]              r_state;
    logic                    r_started;
    logic [AddrBusWidth-1:0] r_haddr;
    logic [1:0]              r_htrans;
    logic                    r_hwrite;
    logic [DataBusWidth-1:0] r_hwdata;
    logic [LW-1:0]           r_left;
    logic                    r_dph_vld;
    logic                    r_dph_wr;
    logic                    r_rsp_valid;
    logic [DataBusWidth-1:0] r_rsp_rdata;
    logic                    r_rsp_last;
    logic                    r_rsp_error;

    logic                    w_addr_ph;
    logic                    w_err;
    logic                    w_dph_ok;
    logic                    w_accept;
    logic [AddrBusWidth-1:0] w_next_addr;
    logic [LW-1:0]           w_len_m1;

    // r_left counts address phases still to issue after the one on the bus
    assign w_addr_ph   = (r_state == S_ADDR) || (r_state == S_BURST);
    assign w_err       = r_dph_vld && HRESP;
    assign w_dph_ok    = r_dph_vld && HREADY && !HRESP;
    assign w_accept    = w_addr_ph && HREADY && !w_err;
    assign w_next_addr = r_haddr + AddrBusWidth'(4);
    assign w_len_m1    = (cmd_len == '0) ? '0 : cmd_len - LW'(1);

    assign cmd_ready = r_started && (r_state == S_IDLE);
    // wr_data is loaded into HWDATA on the same edge a write address phase is accepted
    assign wr_pop    = w_accept && r_hwrite;
    assign HADDR     = r_haddr;
    assign HTRANS    = r_htrans;
    assign HWRITE    = r_hwrite;
    assign HWDATA    = r_hwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_last  = r_rsp_last;
    assign rsp_error = r_rsp_error;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= S_IDLE;
            r_started   <= 1'b0;
            r_haddr     <= '0;
            r_htrans    <= TR_IDLE;
            r_hwrite    <= 1'b0;
            r_hwdata    <= '0;
            r_left      <= '0;
            r_dph_vld   <= 1'b0;
            r_dph_wr    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_last  <= 1'b0;
            r_rsp_error <= 1'b0;
        end else begin
            r_started   <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rsp_error <= 1'b0;

            if (w_dph_ok && !r_dph_wr) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= HRDATA;
                r_rsp_last  <= (r_state == S_LAST);
            end

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        r_state  <= S_ADDR;
                        r_haddr  <= cmd_addr;
                        r_hwrite <= cmd_write;
                        r_htrans <= TR_NONSEQ;
                        r_left   <= w_len_m1;
                    end
                end
                S_ADDR, S_BURST: begin
                    if (w_err) begin
                        r_state   <= S_ERR;
                        r_htrans  <= TR_IDLE;
                        r_dph_vld <= 1'b0;
                    end else if (HREADY) begin
                        r_dph_vld <= 1'b1;
                        r_dph_wr  <= r_hwrite;
                        if (r_hwrite) begin
                            r_hwdata <= wr_data;
                        end
                        if (r_left == '0) begin
                            r_state  <= S_LAST;
                            r_htrans <= TR_IDLE;
                        end else begin
                            // a 1KB boundary restarts the burst with NONSEQ
                            r_state  <= S_BURST;
                            r_haddr  <= w_next_addr;
                            r_htrans <= (w_next_addr[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
                            r_left   <= r_left - LW'(1);
                        end
                    end
                end
                S_LAST: begin
                    if (w_err) begin
                        r_state   <= S_ERR;
                        r_htrans  <= TR_IDLE;
                        r_dph_vld <= 1'b0;
                    end else if (HREADY) begin
                        r_state   <= S_IDLE;
                        r_dph_vld <= 1'b0;
                        if (r_dph_wr) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_last  <= 1'b1;
                        end
                    end
                end
                S_ERR: begin
                    if (HREADY) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_last  <= 1'b1;
                        r_rsp_error <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_htrans <= TR_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Randomized bench for ahb_lite_master: behavioural AHB slave with wait states and an
// error region above 0x800, plus a command-level reference model of bus and responses.
module tb_ahb_lite_master;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MBL = 16;
    localparam int LW  = $clog2(MBL) + 1;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic [DW-1:0] wr_data = '0;
    logic          cmd_ready, wr_pop, rsp_valid, rsp_last, rsp_error, HWRITE;
    logic [DW-1:0] rsp_rdata, HWDATA;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic [DW-1:0] HRDATA = '0;
    logic          HREADY = 1'b1;
    logic          HRESP = 1'b0;

    ahb_lite_master #(.AddrBusWidth(AW), .DataBusWidth(DW), .MaxBurstLen(MBL)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_pop(wr_pop),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last), .rsp_error(rsp_error),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    int n_vec = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_init(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    // stimulus knobs (written by the main process only)
    int wait_pct = 0;
    int force_beat = -1;
    int force_wait = 0;

    // values of the cycle that ends at the next rising edge
    logic          c_ready = 1'b1;
    logic [1:0]    c_trans = 2'b00;
    logic [AW-1:0] c_addr = '0;
    logic          c_write = 1'b0;
    logic [DW-1:0] c_wdata = '0;

    // monitor logs
    logic [AW-1:0] mon_addr[$];
    logic [1:0]    mon_trans[$];
    bit            mon_wr[$];
    logic [DW-1:0] rsp_d[$];
    bit            rsp_l[$];
    bit            rsp_e[$];
    int            pop_total = 0;

    bit            m_prev_ok = 1'b0;
    logic          p_ready = 1'b1;
    logic          p_resp = 1'b0;
    logic [1:0]    p_trans = 2'b00;
    logic [AW-1:0] p_addr = '0;

    always @(negedge HCLK) begin
        c_ready = HREADY;
        c_trans = HTRANS;
        c_addr  = HADDR;
        c_write = HWRITE;
        c_wdata = HWDATA;
        if (rsp_valid) begin
            rsp_d.push_back(rsp_rdata);
            rsp_l.push_back(rsp_last);
            rsp_e.push_back(rsp_error);
        end
        if (!HRESETn) begin
            m_prev_ok = 1'b0;
        end else begin
            if (m_prev_ok && !p_ready && !p_resp && p_trans[1]) begin
                check_eq("stall_haddr", HADDR, p_addr);
                check_eq("stall_htrans", 32'(HTRANS), 32'(p_trans));
            end
            if (m_prev_ok && p_resp && !p_ready)
                check_eq("err_next_idle", 32'(HTRANS), 32'd0);
            if (HREADY && HTRANS[1]) begin
                mon_addr.push_back(HADDR);
                mon_trans.push_back(HTRANS);
                mon_wr.push_back(HWRITE);
            end
            if (wr_pop) pop_total++;
            p_ready = HREADY;
            p_resp = HRESP;
            p_trans = HTRANS;
            p_addr = HADDR;
            m_prev_ok = 1'b1;
        end
    end

    // behavioural slave: 2KB of memory, ERROR for anything at or above 0x800
    logic [31:0]   smem[512];
    bit            s_inited = 1'b0;
    bit            s_pend = 1'b0;
    bit            s_wr = 1'b0;
    bit            s_err = 1'b0;
    bit            s_errph = 1'b0;
    logic [AW-1:0] s_addr = '0;
    int            s_wait = 0;
    int            s_beat = 0;

    always @(posedge HCLK) begin
        #1;
        if (!s_inited) begin
            for (int i = 0; i < 512; i++) smem[i] = mem_init(i);
            s_inited = 1'b1;
        end
        if (!HRESETn) begin
            s_pend = 1'b0;
            HREADY = 1'b1;
            HRESP = 1'b0;
        end else begin
            if (c_ready) begin
                if (s_pend && s_wr && !s_err) smem[s_addr[10:2]] = c_wdata;
                if (c_trans[1]) begin
                    s_pend = 1'b1;
                    s_addr = c_addr;
                    s_wr = c_write;
                    s_err = (c_addr >= 32'h800);
                    s_errph = 1'b0;
                    if (s_beat == force_beat) s_wait = force_wait;
                    else if (int'($urandom_range(99)) < wait_pct) s_wait = int'($urandom_range(2, 1));
                    else s_wait = 0;
                    s_beat++;
                end else begin
                    s_pend = 1'b0;
                end
            end else if (s_pend) begin
                if (s_err) s_errph = 1'b1;
                else if (s_wait > 0) s_wait--;
            end
            if (!s_pend) begin
                HREADY = 1'b1;
                HRESP = 1'b0;
            end else if (s_err) begin
                HREADY = s_errph;
                HRESP = 1'b1;
            end else begin
                HREADY = (s_wait == 0);
                HRESP = 1'b0;
            end
            HRDATA = (s_pend && !s_wr && !s_err && s_wait == 0) ? smem[s_addr[10:2]] : $urandom;
        end
    end

    // write-data source: head of the current command's data list
    logic [DW-1:0] wq[$];
    int            wq_base = 0;
    int            wd_idx = 0;

    always @(posedge HCLK) begin
        #1;
        wd_idx = pop_total - wq_base;
        wr_data = (wd_idx >= 0 && wd_idx < wq.size()) ? wq[wd_idx] : 32'hBAD0_0000;
    end

    logic [31:0] ref_mem[512];

    task automatic issue_cmd(input bit wr, input logic [31:0] addr, input int len);
        int t;
        t = 0;
        while (!cmd_ready && t < 100) begin
            @(posedge HCLK); #1;
            t++;
        end
        check_eq("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr = addr;
        cmd_len = LW'(len);
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr = $urandom;
        cmd_len = LW'($urandom);
    endtask

    task automatic run_cmd(input bit wr, input logic [31:0] addr, input int len,
                           input bit use_d0, input logic [31:0] d0);
        int n, k, n_iss, n_ok, ab, rb, pb, m;
        bit done;
        logic [31:0] a;
        logic [31:0] ea[$];
        logic [1:0]  et[$];
        logic [31:0] xd[$];
        bit xl[$];
        bit xe[$];
        bit xchk[$];
        n = (len == 0) ? 1 : len;
        k = -1;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(4 * i);
            ea.push_back(a);
            et.push_back((i == 0 || a[9:0] == 10'd0) ? 2'b10 : 2'b11);
            if (k < 0 && a >= 32'h800) k = i;
        end
        n_iss = (k < 0) ? n : k + 1;
        n_ok = (k < 0) ? n : k;
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back((use_d0 && i == 0) ? d0 : $urandom);
        wq_base = pop_total;
        ab = mon_addr.size();
        rb = rsp_d.size();
        pb = pop_total;

        issue_cmd(wr, addr, len);
        done = 1'b0;
        for (int c = 0; c < 500 && !done; c++) begin
            @(negedge HCLK);
            if (rsp_valid && rsp_last) done = 1'b1;
        end
        check_eq("rsp_done", 32'(done), 32'd1);
        @(posedge HCLK); #1;

        check_eq("n_addr", 32'(mon_addr.size() - ab), 32'(n_iss));
        m = mon_addr.size() - ab;
        for (int i = 0; i < n_iss && i < m; i++) begin
            check_eq($sformatf("haddr[%0d]", i), mon_addr[ab + i], ea[i]);
            check_eq($sformatf("htrans[%0d]", i), 32'(mon_trans[ab + i]), 32'(et[i]));
            check_eq($sformatf("hwrite[%0d]", i), 32'(mon_wr[ab + i]), 32'(wr));
        end
        check_eq("n_pop", 32'(pop_total - pb), wr ? 32'(n_iss) : 32'd0);

        if (!wr) begin
            for (int i = 0; i < n_ok; i++) begin
                xd.push_back(ref_mem[ea[i][10:2]]);
                xl.push_back(k < 0 && i == n - 1);
                xe.push_back(1'b0);
                xchk.push_back(1'b1);
            end
        end
        if (wr || k >= 0) begin
            xd.push_back(32'd0);
            xl.push_back(1'b1);
            xe.push_back(k >= 0);
            xchk.push_back(1'b0);
        end
        check_eq("n_rsp", 32'(rsp_d.size() - rb), 32'(xd.size()));
        m = rsp_d.size() - rb;
        for (int i = 0; i < xd.size() && i < m; i++) begin
            if (xchk[i]) check_eq($sformatf("rdata[%0d]", i), rsp_d[rb + i], xd[i]);
            check_eq($sformatf("rlast[%0d]", i), 32'(rsp_l[rb + i]), 32'(xl[i]));
            check_eq($sformatf("rerr[%0d]", i), 32'(rsp_e[rb + i]), 32'(xe[i]));
        end
        if (wr)
            for (int i = 0; i < n_ok; i++) ref_mem[ea[i][10:2]] = wq[i];
        check_eq("ready_after", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    bit          r_w;
    logic [31:0] r_a;
    int          r_l, ab0, rb0, t0;

    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = mem_init(i);

        #2 HRESETn = 1'b0;
        #1;
        check_eq("rst_htrans", 32'(HTRANS), 32'd0);
        check_eq("rst_haddr", HADDR, 32'd0);
        check_eq("rst_hwrite", 32'(HWRITE), 32'd0);
        check_eq("rst_hwdata", HWDATA, 32'd0);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_wr_pop", 32'(wr_pop), 32'd0);
        repeat (2) @(posedge HCLK);
        #3 HRESETn = 1'b1;
        @(posedge HCLK); #1;
        check_eq("post_rst_ready", 32'(cmd_ready), 32'd1);

        // single write then read back
        run_cmd(1'b1, 32'h004, 1, 1'b1, 32'hDEADBEEF);
        run_cmd(1'b0, 32'h004, 1, 1'b0, 32'h0);
        check_eq("readback", rsp_d[rsp_d.size() - 1], 32'hDEADBEEF);

        // INCR write of 4, then read of 3 with a 2-cycle stall on beat 2
        run_cmd(1'b1, 32'h400, 4, 1'b0, 32'h0);
        force_beat = s_beat + 1;
        force_wait = 2;
        run_cmd(1'b0, 32'h400, 3, 1'b0, 32'h0);
        force_beat = -1;

        // 1KB crossing, both directions
        run_cmd(1'b1, 32'h3F8, 4, 1'b0, 32'h0);
        run_cmd(1'b0, 32'h3F8, 4, 1'b0, 32'h0);

        // error region: single read, write burst running into it, read burst running into it
        run_cmd(1'b0, 32'hC00, 1, 1'b0, 32'h0);
        run_cmd(1'b1, 32'h7F8, 4, 1'b0, 32'h0);
        run_cmd(1'b0, 32'h7F4, 5, 1'b0, 32'h0);
        run_cmd(1'b0, 32'h7F8, 2, 1'b0, 32'h0);

        // length 0 behaves as one beat
        run_cmd(1'b1, 32'h010, 0, 1'b0, 32'h0);

        // reset in the middle of a read burst
        ab0 = mon_addr.size();
        issue_cmd(1'b0, 32'h100, 4);
        t0 = 0;
        while (mon_addr.size() < ab0 + 2 && t0 < 50) begin
            @(negedge HCLK);
            t0++;
        end
        check_eq("rst_mid_reach", 32'(mon_addr.size() - ab0 >= 2), 32'd1);
        @(posedge HCLK); #3;
        HRESETn = 1'b0;
        rb0 = rsp_d.size();
        #1;
        check_eq("mid_rst_htrans", 32'(HTRANS), 32'd0);
        check_eq("mid_rst_haddr", HADDR, 32'd0);
        check_eq("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        repeat (3) @(posedge HCLK);
        #3 HRESETn = 1'b1;
        repeat (4) @(negedge HCLK);
        check_eq("mid_rst_no_rsp", 32'(rsp_d.size() - rb0), 32'd0);
        check_eq("mid_rst_ready", 32'(cmd_ready), 32'd1);
        @(posedge HCLK); #1;
        run_cmd(1'b0, 32'h100, 4, 1'b0, 32'h0);

        // randomized traffic with wait states
        wait_pct = 30;
        for (int r = 0; r < 40; r++) begin
            r_w = 1'($urandom_range(1));
            if ($urandom_range(7) == 0) r_a = 32'($urandom_range(32'h1FF, 32'h1F8)) * 32'd4;
            else r_a = 32'($urandom_range(32'h1FF)) * 32'd4;
            r_l = int'($urandom_range(16));
            run_cmd(r_w, r_a, r_l, 1'b0, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
